uart_ext: RTL and testbench
===========================

# uart_ext

Parametrised full-duplex UART, successor to the single-cycle-per-bit `UART` block. It adds:
- a configurable baud divisor with mid-bit RX sampling and a two-flop RX synchroniser;
- optional even/odd parity and one or two stop bits;
- a TX busy handshake, and parity/framing error flags on RX.

It sits between the core logic and the serial pins. Two instances are cross-connected for loopback verification.

## Interface
Parameters:
- BIT_LEN, 7, data bits per frame (1..16), sent LSB first
- CLKS_PER_BIT, 4, clock cycles per serial bit; even, ≥4
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, 1 or 2

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- tx_start  in  1  request to send tx_data_in; sampled only while idle
- tx_data_in  in  BIT_LEN  word to transmit; latched on accept
- tx_busy  out  1  high while a frame is being shifted out
- tx_channel_out  out  1  serial TX line; idles at 1
- rx_channel_in  in  1  serial RX line; asynchronous
- rx_data_out  out  BIT_LEN  last received word; held until the next frame completes
- rx_out_vaild  out  1  one-cycle pulse when a frame completes
- rx_parity_err  out  1  parity mismatch in the last frame; held like rx_data_out
- rx_frame_err  out  1  stop bit sampled 0 in the last frame; held like rx_data_out

## Operation
- Frame layout: start(0), BIT_LEN data bits LSB first, parity bit if PARITY≠0, STOP_BITS stop bits(1).
- Parity rules:
  - Even: the parity bit makes the total count of 1s in data+parity even (XOR of the data bits).
  - Odd: the inverse of the even parity bit.
- TX FSM states: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE.
  - Each state holds the line for CLKS_PER_BIT cycles per bit, timed by the baud counter.
  - The bit index counts 0..BIT_LEN-1 in DATA, and 0..STOP_BITS-1 in STOP.
- TX accept: tx_start=1 in IDLE latches tx_data_in.
  - tx_start while busy is ignored; no queuing.
  - tx_start held continuously produces back-to-back frames, with one IDLE cycle between them.
- RX synchroniser: rx_channel_in passes through two flops; the FSM sees only the synchronised value.
- RX FSM states: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE, plus BREAK.
  - IDLE → START on a synchronised 0.
  - In START, wait CLKS_PER_BIT/2 cycles, then re-sample:
    - 1: glitch; return to IDLE with no output.
    - 0: go to DATA.
  - Each following bit is sampled CLKS_PER_BIT cycles after the previous sample.
  - Only the first stop bit is checked; the receiver returns to IDLE after that sample.
- RX frame completion, in the cycle after the stop sample:
  - Update rx_data_out, rx_parity_err and rx_frame_err.
  - Pulse rx_out_vaild for exactly one cycle.
  - A frame with an error still delivers its data and pulses valid.
- Break handling: if the stop sample was 0, enter BREAK and wait for a synchronised 1 before returning to IDLE. A held-low line yields one frame error, not repeated frames.
- Reset (rst=1 at an edge), from any state including mid-frame:
  - Both FSMs go to IDLE.
  - tx_channel_out=1, tx_busy=0.
  - rx_data_out=0, rx_out_vaild=0, rx_parity_err=0, rx_frame_err=0.
  - Baud counters, bit indexes and synchroniser flops are cleared; synchroniser flops are set to 1.

## Timing
- Frame length: N = 1 + BIT_LEN + (PARITY≠0) + STOP_BITS bits, i.e. N×CLKS_PER_BIT cycles.
- Cycle A = the edge that samples tx_start=1 in IDLE.
- TX timing relative to A:
  - From A+1, tx_channel_out=0 and tx_busy=1.
  - Data bit i is driven from A+1+(i+1)×CLKS_PER_BIT.
  - tx_busy falls and the line is 1 (IDLE) at A+1+N×CLKS_PER_BIT.
- RX latency: the start edge is visible to the FSM 2 cycles after it appears on the pin.
- RX valid: rx_out_vaild is high one cycle after the stop mid-sample, i.e. at A+1 + 2 + CLKS_PER_BIT/2 + (N−STOP_BITS)×CLKS_PER_BIT + 1 in a direct loopback.
- Back-to-back frames: RX is in IDLE again before the next start bit, for STOP_BITS≥1.

## Test plan
- Loopback, defaults, tx_data_in=7'h55:
  - tx_busy high for exactly 36 cycles;
  - u1 rx_data_out=7'h55 with a single valid pulse;
  - both error flags 0.
- PARITY=1, data 7'h07:
  - parity bit on the line =1;
  - received 7'h07, parity_err=0.
- PARITY=2, data 7'h07:
  - parity bit =0.
  - Flip the parity bit on the wire → valid pulse, data 7'h07, rx_parity_err=1.
- Framing and glitches:
  - Force the stop bit to 0 → valid, rx_frame_err=1.
  - Hold the line low for 100 cycles → exactly one valid pulse, then no frames until the line is 1.
  - A 1-cycle low glitch on idle RX → no valid pulse, FSM back in IDLE.
- tx_start pulsed again 5 cycles into a frame with data 7'h2A:
  - ignored;
  - only the original word is received.
- STOP_BITS=2, two back-to-back frames 7'h01 then 7'h7F:
  - both received in order.
  - rst asserted mid-DATA → next cycle tx_channel_out=1, tx_busy=0, all RX outputs 0, no spurious valid pulse.

Source files
------------

// File: rtl/uart_ext.sv
// uart_ext: parametrised full-duplex UART with a baud divisor, optional parity,
// one or two stop bits, a TX busy handshake, and RX parity/framing error flags.
// The RX line is synchronised through two flops and sampled mid-bit.
module uart_ext #(
    parameter int BIT_LEN      = 7,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_start,
    input  logic [BIT_LEN-1:0] tx_data_in,
    output logic               tx_busy,
    output logic               tx_channel_out,
    input  logic               rx_channel_in,
    output logic [BIT_LEN-1:0] rx_data_out,
    output logic               rx_out_vaild,
    output logic               rx_parity_err,
    output logic               rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(BIT_LEN + STOP_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(BIT_LEN - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             ODD_PAR   = (PARITY == 2);
    localparam logic             HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    tx_state_t          tx_state;
    logic [CNT_W-1:0]   tx_cnt;
    logic [IDX_W-1:0]   tx_idx;
    logic [BIT_LEN-1:0] tx_shift;
    logic [BIT_LEN-1:0] tx_shift_next;
    logic               tx_par;

    rx_state_t          rx_state;
    logic [CNT_W-1:0]   rx_cnt;
    logic [IDX_W-1:0]   rx_idx;
    logic [BIT_LEN-1:0] rx_shift;
    logic [BIT_LEN-1:0] rx_shift_next;
    logic               rx_par_acc;
    logic               rx_par_bad;
    logic               rx_sync1;
    logic               rx_sync2;

    // Next TX shift value: the following data bit lands in bit 0.
    always_comb begin
        tx_shift_next = tx_shift >> 1;
    end

    // TX frame sequencer; every output it drives is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state       <= TX_IDLE;
            tx_cnt         <= '0;
            tx_idx         <= '0;
            tx_shift       <= '0;
            tx_par         <= 1'b0;
            tx_busy        <= 1'b0;
            tx_channel_out <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_channel_out <= 1'b1;
                    tx_busy        <= 1'b0;
                    if (tx_start) begin
                        tx_shift       <= tx_data_in;
                        tx_par         <= (^tx_data_in) ^ ODD_PAR;
                        tx_cnt         <= '0;
                        tx_channel_out <= 1'b0;
                        tx_busy        <= 1'b1;
                        tx_state       <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt         <= '0;
                        tx_idx         <= '0;
                        tx_channel_out <= tx_shift[0];
                        tx_state       <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == DATA_LAST) begin
                            tx_idx <= '0;
                            if (HAS_PAR) begin
                                tx_channel_out <= tx_par;
                                tx_state       <= TX_PARITY;
                            end else begin
                                tx_channel_out <= 1'b1;
                                tx_state       <= TX_STOP;
                            end
                        end else begin
                            tx_idx         <= tx_idx + 1'b1;
                            tx_shift       <= tx_shift_next;
                            tx_channel_out <= tx_shift_next[0];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_PARITY: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt         <= '0;
                        tx_idx         <= '0;
                        tx_channel_out <= 1'b1;
                        tx_state       <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == STOP_LAST) begin
                            tx_idx         <= '0;
                            tx_busy        <= 1'b0;
                            tx_channel_out <= 1'b1;
                            tx_state       <= TX_IDLE;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_channel_out <= 1'b1;
                    tx_busy        <= 1'b0;
                    tx_state       <= TX_IDLE;
                end
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous RX pin; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
        end else begin
            rx_sync1 <= rx_channel_in;
            rx_sync2 <= rx_sync1;
        end
    end

    // Next RX shift value: sampled bit enters at the MSB so the first bit ends at bit 0.
    always_comb begin
        rx_shift_next              = rx_shift >> 1;
        rx_shift_next[BIT_LEN-1]   = rx_sync2;
    end

    // RX frame sequencer: mid-bit sampling, error capture and the one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_idx        <= '0;
            rx_shift      <= '0;
            rx_par_acc    <= 1'b0;
            rx_par_bad    <= 1'b0;
            rx_data_out   <= '0;
            rx_out_vaild  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_out_vaild <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync2) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == CNT_HALF) begin
                        rx_cnt <= '0;
                        if (rx_sync2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_idx     <= '0;
                            rx_par_acc <= 1'b0;
                            rx_par_bad <= 1'b0;
                            rx_state   <= RX_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt     <= '0;
                        rx_shift   <= rx_shift_next;
                        rx_par_acc <= rx_par_acc ^ rx_sync2;
                        if (rx_idx == DATA_LAST) begin
                            rx_idx   <= '0;
                            rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt     <= '0;
                        rx_par_bad <= rx_par_acc ^ rx_sync2 ^ ODD_PAR;
                        rx_state   <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt        <= '0;
                        rx_data_out   <= rx_shift;
                        rx_out_vaild  <= 1'b1;
                        rx_parity_err <= rx_par_bad;
                        rx_frame_err  <= ~rx_sync2;
                        rx_state      <= rx_sync2 ? RX_IDLE : RX_BREAK;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_BREAK: begin
                    if (rx_sync2) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ext.sv
// tb_uart_ext: directed loopback scenarios for uart_ext across parity and stop-bit variants.
module tb_uart_ext;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] tx_data = 7'h00;
    logic       st_0 = 1'b0, st_1 = 1'b0, st_e = 1'b0, st_o = 1'b0, st_s = 1'b0;
    logic       inj_en = 1'b0, inj_val = 1'b1, flip = 1'b0;

    logic       u0_busy, u0_tx, u0_vld, u0_perr, u0_ferr;
    logic       u1_busy, u1_tx, u1_vld, u1_perr, u1_ferr;
    logic       ue_busy, ue_tx, ue_vld, ue_perr, ue_ferr;
    logic       uo_busy, uo_tx, uo_vld, uo_perr, uo_ferr;
    logic       us_busy, us_tx, us_vld, us_perr, us_ferr;
    logic [6:0] u0_data, u1_data, ue_data, uo_data, us_data;
    logic       u1_rx, uo_rx;

    int checks = 0;
    int errors = 0;
    int n_u1 = 0, n_e = 0, n_o = 0, n_s = 0;
    logic [6:0] hist_s [4];
    int base, busy_cyc, vk;

    always #5 clk = ~clk;

    // u1 receives u0's line, optionally overridden to force stop bits, breaks and glitches.
    assign u1_rx = inj_en ? inj_val : u0_tx;
    // The odd-parity instance loops back through an XOR so single bits can be corrupted.
    assign uo_rx = uo_tx ^ flip;

    uart_ext u0 (.clk(clk), .rst(rst), .tx_start(st_0), .tx_data_in(tx_data),
                 .tx_busy(u0_busy), .tx_channel_out(u0_tx), .rx_channel_in(u1_tx),
                 .rx_data_out(u0_data), .rx_out_vaild(u0_vld),
                 .rx_parity_err(u0_perr), .rx_frame_err(u0_ferr));

    uart_ext u1 (.clk(clk), .rst(rst), .tx_start(st_1), .tx_data_in(tx_data),
                 .tx_busy(u1_busy), .tx_channel_out(u1_tx), .rx_channel_in(u1_rx),
                 .rx_data_out(u1_data), .rx_out_vaild(u1_vld),
                 .rx_parity_err(u1_perr), .rx_frame_err(u1_ferr));

    uart_ext #(.PARITY(1)) ue (.clk(clk), .rst(rst), .tx_start(st_e), .tx_data_in(tx_data),
                 .tx_busy(ue_busy), .tx_channel_out(ue_tx), .rx_channel_in(ue_tx),
                 .rx_data_out(ue_data), .rx_out_vaild(ue_vld),
                 .rx_parity_err(ue_perr), .rx_frame_err(ue_ferr));

    uart_ext #(.PARITY(2)) uo (.clk(clk), .rst(rst), .tx_start(st_o), .tx_data_in(tx_data),
                 .tx_busy(uo_busy), .tx_channel_out(uo_tx), .rx_channel_in(uo_rx),
                 .rx_data_out(uo_data), .rx_out_vaild(uo_vld),
                 .rx_parity_err(uo_perr), .rx_frame_err(uo_ferr));

    uart_ext #(.STOP_BITS(2)) us (.clk(clk), .rst(rst), .tx_start(st_s), .tx_data_in(tx_data),
                 .tx_busy(us_busy), .tx_channel_out(us_tx), .rx_channel_in(us_tx),
                 .rx_data_out(us_data), .rx_out_vaild(us_vld),
                 .rx_parity_err(us_perr), .rx_frame_err(us_ferr));

    // Count valid pulses per receiver and keep the words delivered by the two-stop-bit one.
    always @(negedge clk) begin
        if (u1_vld) n_u1++;
        if (ue_vld) n_e++;
        if (uo_vld) n_o++;
        if (us_vld) begin
            if (n_s < 4) hist_s[n_s] = us_data;
            n_s++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Raises one transmitter's start for a single edge; returns one negedge after that edge.
    task automatic apply_stimulus(input int which, input logic [6:0] d);
        @(negedge clk);
        tx_data = d;
        case (which)
            0: st_0 = 1'b1;
            1: st_e = 1'b1;
            default: st_o = 1'b1;
        endcase
        @(negedge clk);
        st_0 = 1'b0;
        st_e = 1'b0;
        st_o = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge clk);
        check_output("rst_tx_line", u0_tx, 1);
        check_output("rst_tx_busy", u0_busy, 0);
        check_output("rst_rx_data", u1_data, 0);
        check_output("rst_rx_valid", u1_vld, 0);
        check_output("rst_rx_perr", u1_perr, 0);
        check_output("rst_rx_ferr", u1_ferr, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Default loopback of 7'h55, with busy length and valid timing.
        $display("[TB] loopback 55");
        base = n_u1;
        busy_cyc = 0;
        vk = 0;
        apply_stimulus(0, 7'h55);
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (u0_busy) busy_cyc++;
            if (u1_vld && vk == 0) vk = k;
            if (k == 1) check_output("start_bit", u0_tx, 0);
            if (k == 5) check_output("data_bit0", u0_tx, 1);
            if (k == 9) check_output("data_bit1", u0_tx, 0);
        end
        check_output("busy_cycles", busy_cyc, 36);
        check_output("valid_time", vk, 38);
        check_output("valid_count", n_u1 - base, 1);
        check_output("rx_data_55", u1_data, 7'h55);
        check_output("rx_perr_55", u1_perr, 0);
        check_output("rx_ferr_55", u1_ferr, 0);

        // Even parity on 7'h07.
        $display("[TB] even parity");
        base = n_e;
        busy_cyc = 0;
        apply_stimulus(1, 7'h07);
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (ue_busy) busy_cyc++;
            if (k == 34) check_output("even_par_bit", ue_tx, 1);
        end
        check_output("even_busy_cycles", busy_cyc, 40);
        check_output("even_valid_count", n_e - base, 1);
        check_output("even_rx_data", ue_data, 7'h07);
        check_output("even_rx_perr", ue_perr, 0);

        // Odd parity on 7'h07, clean then with the parity bit flipped on the wire.
        $display("[TB] odd parity");
        base = n_o;
        apply_stimulus(2, 7'h07);
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 34) check_output("odd_par_bit", uo_tx, 0);
        end
        check_output("odd_rx_data", uo_data, 7'h07);
        check_output("odd_rx_perr", uo_perr, 0);
        apply_stimulus(2, 7'h07);
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 33) flip = 1'b1;
            if (k == 37) flip = 1'b0;
        end
        check_output("odd_valid_count", n_o - base, 2);
        check_output("odd_bad_data", uo_data, 7'h07);
        check_output("odd_bad_perr", uo_perr, 1);
        check_output("odd_bad_ferr", uo_ferr, 0);

        // Stop bit forced low.
        $display("[TB] forced stop low");
        base = n_u1;
        apply_stimulus(0, 7'h55);
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 33) begin
                inj_val = 1'b0;
                inj_en  = 1'b1;
            end
            if (k == 41) inj_en = 1'b0;
        end
        check_output("stop0_valid_count", n_u1 - base, 1);
        check_output("stop0_data", u1_data, 7'h55);
        check_output("stop0_ferr", u1_ferr, 1);
        check_output("stop0_perr", u1_perr, 0);

        // Line held low for 100 cycles: one frame error, then silence.
        $display("[TB] break");
        base = n_u1;
        inj_val = 1'b0;
        inj_en  = 1'b1;
        repeat (100) @(negedge clk);
        check_output("break_valid_count", n_u1 - base, 1);
        check_output("break_data", u1_data, 7'h00);
        check_output("break_ferr", u1_ferr, 1);
        inj_val = 1'b1;
        repeat (20) @(negedge clk);
        inj_en = 1'b0;
        repeat (40) @(negedge clk);
        check_output("break_after_release", n_u1 - base, 1);

        // Single-cycle low glitch on idle RX.
        $display("[TB] glitch");
        base = n_u1;
        @(negedge clk);
        inj_val = 1'b0;
        inj_en  = 1'b1;
        @(negedge clk);
        inj_en  = 1'b0;
        inj_val = 1'b1;
        repeat (50) @(negedge clk);
        check_output("glitch_valid_count", n_u1 - base, 0);

        // Second start request mid-frame is ignored.
        $display("[TB] start while busy");
        base = n_u1;
        apply_stimulus(0, 7'h13);
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 5) begin
                tx_data = 7'h2A;
                st_0    = 1'b1;
            end
            if (k == 6) st_0 = 1'b0;
        end
        check_output("busy_ignore_count", n_u1 - base, 1);
        check_output("busy_ignore_data", u1_data, 7'h13);
        check_output("busy_ignore_ferr", u1_ferr, 0);
        check_output("busy_ignore_idle", u0_busy, 0);

        // Two stop bits, back-to-back frames from a held start.
        $display("[TB] two stop bits back-to-back");
        base = n_s;
        @(negedge clk);
        tx_data = 7'h01;
        st_s    = 1'b1;
        @(negedge clk);
        tx_data = 7'h7F;
        for (int k = 2; k <= 100; k++) begin
            @(negedge clk);
            if (k == 41) check_output("b2b_idle_gap", us_busy, 0);
            if (k == 42) begin
                st_s = 1'b0;
                check_output("b2b_second_busy", us_busy, 1);
            end
        end
        check_output("b2b_count", n_s - base, 2);
        check_output("b2b_first", hist_s[0], 7'h01);
        check_output("b2b_second", hist_s[1], 7'h7F);
        check_output("b2b_ferr", us_ferr, 0);

        // Reset in the middle of a data bit.
        $display("[TB] reset mid-frame");
        base = n_u1;
        apply_stimulus(0, 7'h55);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("mid_rst_tx_line", u0_tx, 1);
        check_output("mid_rst_busy", u0_busy, 0);
        check_output("mid_rst_rx_data", u1_data, 0);
        check_output("mid_rst_rx_valid", u1_vld, 0);
        check_output("mid_rst_rx_perr", u1_perr, 0);
        check_output("mid_rst_rx_ferr", u1_ferr, 0);
        check_output("mid_rst_s_data", us_data, 0);
        repeat (60) @(negedge clk);
        check_output("mid_rst_no_valid", n_u1 - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
